// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants for the round-robin N:1 collector.
//   NUM_CH_DEF / DATA_W_DEF : default channel count and word width
//   clog2_ch()              : channel-index width helper (minimum 1 bit)
//   EMPTY / FULL            : output-stage state encoding (state == out_valid)
package rr_mux_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  // Smallest w with 2**w >= n, never below 1 so a 2-channel build still has an index bit.
  function automatic int clog2_ch(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational one-hot arbiter.
//   req     [NUM_CH] : per-channel request
//   ptr     [CH_W]   : highest-priority channel this cycle (round-robin start)
//   gnt     [NUM_CH] : one-hot grant (all zero when no request)
//   gnt_idx [CH_W]   : binary index of the granted channel (0 when none)
//   any_gnt          : at least one request is granted
// Configuration macro RR_MUX_FIXED_PRIO_EN: when defined the lowest-index
// request always wins and ptr is ignored.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int  NUM_CH = NUM_CH_DEF,
  localparam int CH_W   = clog2_ch(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any_gnt
);

`ifdef RR_MUX_FIXED_PRIO_EN
  // ptr has no role in fixed priority; fold it away explicitly.
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr;

  // Fixed priority: scan upward from channel 0, first request wins.
  always_comb begin
    logic [CH_W-1:0] idx_s;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = CH_W'(k);
      if (!any_gnt && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        any_gnt    = 1'b1;
      end else begin
        any_gnt = any_gnt;
      end
    end
  end
`else
  // Round-robin: scan ptr, ptr+1, ... wrapping at NUM_CH (not a power of two
  // in general, so the wrap is an explicit subtract rather than a bit mask).
  always_comb begin
    int              cand_s;
    logic [CH_W-1:0] idx_s;
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand_s  = 0;
    idx_s   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_s = int'(ptr) + k;
      if (cand_s >= NUM_CH) begin
        cand_s = cand_s - NUM_CH;
      end else begin
        cand_s = cand_s;
      end
      idx_s = CH_W'(cand_s);
      if (!any_gnt && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        any_gnt    = 1'b1;
      end else begin
        any_gnt = any_gnt;
      end
    end
  end
`endif

endmodule

// File: rtl/rr_mux_collector.sv
// rr_mux_collector: N:1 time-multiplexing collector with one registered
// output stage and a valid/ready handshake on both sides.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   in_valid [NUM_CH] : per-channel request
//   in_data           : NUM_CH words, channel i at [i*DATA_W +: DATA_W]
//   in_ready [NUM_CH] : one-hot (or zero) take strobe for the granted channel
//   out_valid         : output register holds a word
//   out_data [DATA_W] : collected word
//   out_ch   [CH_W]   : source channel of out_data
//   out_ready         : consumer accepts the word
// Configuration macro RR_MUX_FIXED_PRIO_EN: when defined the round-robin
// pointer is removed and the lowest-index valid channel always wins.
module rr_mux_collector
  import rr_mux_pkg::*;
#(
  parameter int  NUM_CH = NUM_CH_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int CH_W   = clog2_ch(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  logic              state_r;
  logic              state_next_s;
  logic              load_s;
  logic              transfer_s;
  logic [NUM_CH-1:0] gnt_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic              any_gnt_s;
  logic [NUM_CH-1:0] in_ready_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [DATA_W-1:0] out_data_r;
  logic [CH_W-1:0]   out_ch_r;
  logic [CH_W-1:0]   ptr_s;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr_s = '0;
`else
  logic [CH_W-1:0] ptr_r;
  assign ptr_s = ptr_r;

  // Round-robin pointer: one past the last winner, moves only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (transfer_s) begin
      if (gnt_idx_s == CH_W'(NUM_CH - 1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= gnt_idx_s + CH_W'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any_gnt (any_gnt_s)
  );

  // The stage can accept a word when it is empty or being drained this cycle.
  assign load_s     = (state_r == EMPTY) || out_ready;
  assign transfer_s = |(in_valid & in_ready_s);

  // One-hot word select driven by the grant vector.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_s[i]) begin
        sel_data_s = in_data[i*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // State register: EMPTY/FULL is exactly out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: any transfer fills the stage; a drain without refill empties it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (transfer_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (transfer_s) begin
          state_next_s = FULL;
        end else if (out_ready) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Handshake outputs: grant is gated by load, and forced low while in reset.
  always_comb begin
    in_ready_s = '0;
    if (rst) begin
      in_ready_s = '0;
    end else if (load_s) begin
      in_ready_s = gnt_s;
    end else begin
      in_ready_s = '0;
    end
  end

  // Output word/channel register: loads on transfer, otherwise keeps stale value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r <= '0;
      out_ch_r   <= '0;
    end else if (transfer_s) begin
      out_data_r <= sel_data_s;
      out_ch_r   <= gnt_idx_s;
    end else begin
      out_data_r <= out_data_r;
      out_ch_r   <= out_ch_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == FULL);
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_rr_mux_collector.sv
// Directed testbench for rr_mux_collector (NUM_CH=4, DATA_W=8).
// Inputs change 1 time unit after each rising edge; outputs are checked
// there too, so registered values reflect the edge just taken and
// in_ready reflects the inputs just applied.
module tb_rr_mux_collector;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;

  int tests_run;
  int tests_failed;

  rr_mux_collector #(
    .NUM_CH (4),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] ch, input logic [7:0] d);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".out_ch"},    {30'd0, out_ch},    {30'd0, ch});
    check({tag, ".out_data"},  {24'd0, out_data},  {24'd0, d});
  endtask

  logic [7:0] exp_data [4];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_data[0] = 8'h10; exp_data[1] = 8'h21; exp_data[2] = 8'h32; exp_data[3] = 8'h43;

    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    out_ready = 1'b1;
    #1;
    check_out("reset", 1'b0, 2'd0, 8'h00);
    check("reset.in_ready", {28'd0, in_ready}, 32'h0);
    step();
    step();
    rst = 1'b0;
    #0;

`ifdef RR_MUX_FIXED_PRIO_EN
    #1;
    check("fixed.in_ready0", {28'd0, in_ready}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("fixed.all", 1'b1, 2'd0, 8'h10);
    end
    in_valid = 4'b1110;
    #1;
    check("fixed.in_ready1", {28'd0, in_ready}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("fixed.no_ch0", 1'b1, 2'd1, 8'h21);
    end
`else
    // Full contention: strict 0,1,2,3,0 order, one word per clock.
    #1;
    check("rr.first_gnt", {28'd0, in_ready}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("rr.contention", 1'b1, 2'(i % 4), exp_data[i % 4]);
    end
    check("rr.next_gnt", {28'd0, in_ready}, 32'h2);

    // Backpressure: hold 5 clocks, in_ready low, output frozen.
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp.in_ready", {28'd0, in_ready}, 32'h0);
      step();
      check_out("bp.hold", 1'b1, 2'd0, 8'h10);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_rdy", {28'd0, in_ready}, 32'h2);
    step();
    check_out("bp.drain_load", 1'b1, 2'd1, 8'h21);

    // Wrap skip: grant ch2 (ptr->3), then only ch0/ch1 valid.
    in_valid = 4'b0100;
    #1;
    check("wrap.gnt2", {28'd0, in_ready}, 32'h4);
    step();
    check_out("wrap.ch2", 1'b1, 2'd2, 8'h32);
    in_valid = 4'b0011;
    #1;
    check("wrap.gnt0", {28'd0, in_ready}, 32'h1);
    step();
    check_out("wrap.ch0", 1'b1, 2'd0, 8'h10);
    check("wrap.gnt1", {28'd0, in_ready}, 32'h2);
    step();
    check_out("wrap.ch1", 1'b1, 2'd1, 8'h21);

    // Sparse: ch2 alone for one cycle, then nothing valid.
    in_valid = 4'b0100;
    step();
    check_out("sparse.load", 1'b1, 2'd2, 8'h32);
    in_valid = 4'b0000;
    #1;
    check("sparse.idle_rdy", {28'd0, in_ready}, 32'h0);
    step();
    check_out("sparse.drain", 1'b0, 2'd2, 8'h32);
    step();
    check_out("sparse.idle", 1'b0, 2'd2, 8'h32);
    in_valid = 4'b1111;
    #1;
    check("sparse.ptr_held", {28'd0, in_ready}, 32'h8);

    // Reset mid-stream: load A5 from ch3, stall, then assert rst between edges.
    in_data = {8'hA5, 8'h32, 8'h21, 8'h10};
    step();
    check_out("rst.loaded", 1'b1, 2'd3, 8'hA5);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_out("rst.async", 1'b0, 2'd0, 8'h00);
    check("rst.in_ready", {28'd0, in_ready}, 32'h0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst.first_gnt", {28'd0, in_ready}, 32'h1);
    step();
    check_out("rst.after", 1'b1, 2'd0, 8'h10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_mux_collector.md
Name: rr_mux_collector

Overview:
- N:1 time-multiplexing collector. It is the merge end for a 1:N demux-style fan-out.
- Each cycle it picks one of NUM_CH valid input channels in round-robin order and loads that channel's word into a single registered output stage.
- The output carries the word and its source channel index.
- It sits downstream of the demux fabric and feeds one shared consumer through a valid/ready handshake.

Parameters:
- NUM_CH, 4, number of input channels. Legal range 2..16, any integer, not only powers of two.
- DATA_W, 8, width of each channel word.
- CH_W, $clog2(NUM_CH), width of the channel index (derived, not overridden).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel request. Bit i means in_data slice i is valid.
- in_data  input  NUM_CH*DATA_W  channel words. Channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  one-hot or zero. Bit i means channel i's word is taken this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_W  collected word.
- out_ch  output  CH_W  source channel of out_data.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr pointer=0, in_ready=0. Any held word is discarded.
- load = !out_valid || out_ready. This is combinational.
- Grant:
  - Search begins at channel ptr and proceeds ptr, ptr+1, …, wrapping modulo NUM_CH.
  - The first channel with in_valid=1 wins.
  - in_ready[win]=load. All other in_ready bits are 0.
  - in_ready never depends on in_data.
- Transfer on channel i: in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= slice i
  - out_ch <= i
  - out_valid <= 1
  - ptr <= (i+1) mod NUM_CH, with explicit wrap from NUM_CH-1 to 0.
- Drain: if out_valid && out_ready and no input transfers, out_valid <= 0. out_data and out_ch keep their stale values.
- Simultaneous drain + load: both happen in the same cycle. Throughput is 1 word/clk and out_valid stays 1.
- Stall: out_valid && !out_ready. Then in_ready=0, and out_valid, out_data and out_ch hold stable.
- Pointer: updates only on a transfer. When no channel is valid, ptr holds.
- Latency: input transfer to out_valid is 1 clk.
- Fairness: with all channels continuously valid and out_ready=1, the grant order is 0,1,…,NUM_CH-1,0,… and no channel waits more than NUM_CH-1 transfers.
- State view (2 states):
  - EMPTY (out_valid=0): moves to FULL on any transfer.
  - FULL (out_valid=1): stays FULL on transfer or stall; moves to EMPTY on out_ready with no transfer.

Optional Feature:
- Macro: RR_MUX_FIXED_PRIO_EN.
- Defined:
  - Round-robin is replaced by fixed priority: the lowest-index valid channel wins.
  - The ptr register is removed.
  - All handshake, output register and latency rules are unchanged.
- Undefined: round-robin exactly as specified above.

Decomposition:
- Package rr_mux_pkg holds:
  - default constants NUM_CH_DEF=4 and DATA_W_DEF=8
  - a function clog2_ch for CH_W
  - the EMPTY/FULL state encoding as localparams (EMPTY=1'b0, FULL=1'b1).
- Sub-module rr_arbiter:
  - Purely combinational.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: one-hot gnt[NUM_CH], gnt_idx[CH_W], any_gnt.
  - It contains the fixed-priority variant under RR_MUX_FIXED_PRIO_EN.
- rr_mux_collector owns ptr, the output register and the handshake.

Test Plan:
- Reset mid-stream: pulse rst while out_valid=1, out_data=8'hA5 → outputs go to 0 immediately (async), ptr=0, and the first grant after release goes to channel 0 when all channels are valid.
- Full contention: in_valid=4'b1111 with data 8'h10,8'h21,8'h32,8'h43, out_ready=1 → out_ch sequence 0,1,2,3,0, out_data 10,21,32,43,10, one word per clk after 1-clk latency.
- Wrap skip: ptr=3 (after a grant to ch2), in_valid=4'b0011 → ch0 granted and ptr becomes 1. Next grant is ch1.
- Backpressure: out_ready=0 for 5 clk with out_valid=1 → in_ready=0, and out_data/out_ch are stable. On release, the held word drains and the next word loads in the same cycle.
- Sparse: only ch2 valid for one cycle, out_ready=1 → out_valid=1 for exactly one cycle with out_ch=2, then 0 while ptr=3 holds.
- With RR_MUX_FIXED_PRIO_EN: in_valid=4'b1111 held → out_ch is always 0. Drop ch0 → out_ch is always 1.
